// File: rtl/mano_core_param.sv
// mano_core_param: Mano basic-computer core with full MRI/RRI sets, indirect addressing and start/HLT control.
// Memory is external, single-port, with combinational read; mem_addr always mirrors AR.
module mano_core_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] ir,
    output logic              e,
    output logic [2:0]        sc
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} state_t;
    localparam logic [2:0] OP_AND = 3'd0, OP_ADD = 3'd1, OP_LDA = 3'd2, OP_STA = 3'd3,
                           OP_BUN = 3'd4, OP_BSA = 3'd5, OP_ISZ = 3'd6, OP_RIO = 3'd7;
    state_t state, state_nx;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] dr, ac_rr;
    logic [DATA_W:0] sum;
    logic [2:0] op;
    logic [11:0] rr;
    logic ind, rri, ld, e_rr, skip;
    assign ind = ir[DATA_W-1];
    assign op = ir[DATA_W-2:DATA_W-4];
    assign rr = ir[11:0];
    assign rri = op == OP_RIO && !ind;
    assign ld = op == OP_AND || op == OP_ADD || op == OP_LDA || op == OP_ISZ;
    assign sum = {1'b0, ac} + {1'b0, dr};
    assign mem_addr = ar;
    assign sc = state;
    // Every register-reference op sees AC/E as they stood at the start of T3.
    assign ac_rr = rr[11] ? '0 : rr[9] ? ~ac : rr[5] ? ac + DATA_W'(1) :
                   rr[7] ? {e, ac[DATA_W-1:1]} : rr[6] ? {ac[DATA_W-2:0], e} : ac;
    assign e_rr = rr[10] ? 1'b0 : rr[8] ? ~e : rr[7] ? ac[0] : rr[6] ? ac[DATA_W-1] : e;
    assign skip = (rr[4] && !ac[DATA_W-1]) || (rr[3] && ac[DATA_W-1]) ||
                  (rr[2] && ac == '0) || (rr[1] && !e);
    always_comb begin
        state_nx = T0;
        if (run) begin
            case (state)
                T0: state_nx = T1;
                T1: state_nx = T2;
                T2: state_nx = T3;
                T3: state_nx = op == OP_RIO ? T0 : T4;
                T4: state_nx = (op == OP_STA || op == OP_BUN) ? T0 : T5;
                T5: state_nx = op == OP_ISZ ? T6 : T0;
                default: state_nx = T0;
            endcase
        end
    end
    always_ff @(posedge CLK) state <= rst ? T0 : state_nx;
    always_comb begin
        mem_wdata = '0;
        mem_we = 1'b0;
        mem_re = 1'b0;
        if (run) begin
            mem_wdata = (state == T4 && op == OP_STA) ? ac :
                        (state == T4 && op == OP_BSA) ? DATA_W'(pc) :
                        (state == T6 && op == OP_ISZ) ? dr : '0;
            // Gating with rst keeps an aborted instruction from landing a write.
            mem_we = !rst && ((state == T4 && (op == OP_STA || op == OP_BSA)) ||
                              (state == T6 && op == OP_ISZ));
            mem_re = state == T1 || (state == T3 && op != OP_RIO && ind) || (state == T4 && ld);
        end
    end
    always_ff @(posedge CLK) begin
        if (rst) begin
            ac <= '0;
            dr <= '0;
            ir <= '0;
            ar <= '0;
            e <= 1'b0;
            pc <= RESET_PC;
            run <= 1'b0;
        end else begin
            if (start && !run) run <= 1'b1;
            if (run) begin
                case (state)
                    T0: ar <= pc;
                    T1: begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                    T2: ar <= ir[ADDR_W-1:0];
                    T3: begin
                        if (op != OP_RIO && ind) ar <= mem_rdata[ADDR_W-1:0];
                        else if (rri) begin
                            ac <= ac_rr;
                            e <= e_rr;
                            if (skip) pc <= pc + ADDR_W'(1);
                            if (rr[0]) run <= 1'b0;
                        end
                    end
                    T4: begin
                        if (ld) dr <= mem_rdata;
                        else if (op == OP_BUN) pc <= ar;
                        else if (op == OP_BSA) ar <= ar + ADDR_W'(1);
                    end
                    T5: begin
                        if (op == OP_AND) ac <= ac & dr;
                        else if (op == OP_ADD) {e, ac} <= sum;
                        else if (op == OP_LDA) ac <= dr;
                        else if (op == OP_BSA) pc <= ar;
                        else if (op == OP_ISZ) dr <= dr + DATA_W'(1);
                    end
                    T6: if (dr == '0) pc <= pc + ADDR_W'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mano_core_param.sv
// tb_mano_core_param: directed programs; expected halts and memory writes are queued and checked by monitors.
module tb_mano_core_param;
    logic CLK = 1'b0;
    logic rst = 1'b1, start = 1'b0;
    logic [11:0] mem_addr, pc;
    logic [15:0] mem_rdata, mem_wdata, ac, ir;
    logic mem_we, mem_re, run, e;
    logic [2:0] sc;
    logic [15:0] mem [0:4095];
    logic ld_we = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    typedef struct packed {logic [15:0] ac; logic e; logic [11:0] pc;} halt_t;
    typedef struct packed {logic [11:0] addr; logic [15:0] data;} wr_t;
    halt_t halt_q[$];
    wr_t wr_q[$];
    halt_t hq;
    wr_t wq;
    int n_cmp = 0, n_fail = 0;
    logic prev_run = 1'b0;
    logic [2:0] prev_sc = 3'd0;
    mano_core_param dut (
        .CLK(CLK), .rst(rst), .start(start), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .run(run), .pc(pc),
        .ac(ac), .ir(ir), .e(e), .sc(sc)
    );
    always #5 CLK = ~CLK;
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge CLK) begin
        if (prev_run && !run && prev_sc == 3'd3) begin
            if (halt_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL halt_unexpected: got halt at pc=%h expected none", pc);
            end else begin
                hq = halt_q.pop_front();
                check("halt_ac", {16'h0, ac}, {16'h0, hq.ac});
                check("halt_e", {31'h0, e}, {31'h0, hq.e});
                check("halt_pc", {20'h0, pc}, {20'h0, hq.pc});
            end
        end
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL write_unexpected: got write %h@%h expected none", mem_wdata, mem_addr);
            end else begin
                wq = wr_q.pop_front();
                check("write_addr", {20'h0, mem_addr}, {20'h0, wq.addr});
                check("write_data", {16'h0, mem_wdata}, {16'h0, wq.data});
            end
        end
        prev_run = run;
        prev_sc = sc;
    end
    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_we = 1'b1;
        @(posedge CLK);
        #1 ld_we = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge CLK) rst = 1'b1;
        @(negedge CLK) rst = 1'b0;
    endtask
    task automatic go();
        @(negedge CLK) start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask
    task automatic wait_done();
        int k;
        for (k = 0; k < 400; k++) begin
            if (halt_q.size() == 0 && wr_q.size() == 0 && !run) break;
            @(posedge CLK);
            #1;
        end
        check("idle_in_time", {31'h0, halt_q.size() == 0 && wr_q.size() == 0 && !run}, 32'h1);
    endtask
    initial begin
        logic [5:0] re_exp;
        bit found;
        re_exp = 6'b011010;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ac", {16'h0, ac}, 32'h0);
        check("rst_pc", {20'h0, pc}, 32'h0);
        check("rst_ir", {16'h0, ir}, 32'h0);
        check("rst_e", {31'h0, e}, 32'h0);
        check("rst_sc", {29'h0, sc}, 32'h0);
        check("rst_run", {31'h0, run}, 32'h0);
        check("rst_we", {31'h0, mem_we}, 32'h0);
        check("rst_re", {31'h0, mem_re}, 32'h0);
        rst = 1'b0;
        // LDA then HLT, with cycle-exact timing
        poke(12'h000, 16'h2010);
        poke(12'h010, 16'h1234);
        poke(12'h001, 16'h7001);
        halt_q.push_back('{16'h1234, 1'b0, 12'h002});
        go();
        repeat (5) @(posedge CLK);
        #1 check("lda_ac_t4", {16'h0, ac}, 32'h0);
        @(posedge CLK);
        #1 check("lda_ac_t5", {16'h0, ac}, 32'h1234);
        repeat (3) @(posedge CLK);
        #1 check("hlt_run_t3", {31'h0, run}, 32'h1);
        @(posedge CLK);
        #1 check("hlt_run_end", {31'h0, run}, 32'h0);
        wait_done();
        // ADD overflow into E, then resume with AND
        do_reset();
        poke(12'h000, 16'h2020);
        poke(12'h001, 16'h1021);
        poke(12'h002, 16'h7001);
        poke(12'h003, 16'h2022);
        poke(12'h004, 16'h0023);
        poke(12'h005, 16'h7001);
        poke(12'h020, 16'hFFFF);
        poke(12'h021, 16'h0001);
        poke(12'h022, 16'h00FF);
        poke(12'h023, 16'h0F0F);
        halt_q.push_back('{16'h0000, 1'b1, 12'h003});
        go();
        wait_done();
        halt_q.push_back('{16'h000F, 1'b1, 12'h006});
        go();
        wait_done();
        // indirect LDA with mem_re profile
        do_reset();
        poke(12'h000, 16'hA005);
        poke(12'h005, 16'h0020);
        poke(12'h020, 16'hBEEF);
        poke(12'h001, 16'h7001);
        halt_q.push_back('{16'hBEEF, 1'b0, 12'h002});
        go();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ind_re_t%0d", i), {31'h0, mem_re}, {31'h0, re_exp[i]});
            @(posedge CLK);
            #1;
        end
        wait_done();
        // SZA skip, then CMA|INC where CMA wins
        do_reset();
        poke(12'h000, 16'h7004);
        poke(12'h002, 16'h7220);
        poke(12'h003, 16'h7001);
        halt_q.push_back('{16'hFFFF, 1'b0, 12'h004});
        go();
        wait_done();
        // ISZ with wrap (skip) and without
        do_reset();
        poke(12'h000, 16'h6030);
        poke(12'h001, 16'h2031);
        poke(12'h002, 16'h7001);
        poke(12'h030, 16'hFFFF);
        poke(12'h031, 16'h5555);
        wr_q.push_back('{12'h030, 16'h0000});
        halt_q.push_back('{16'h0000, 1'b0, 12'h003});
        go();
        wait_done();
        check("isz_mem_wrap", {16'h0, mem[12'h030]}, 32'h0);
        do_reset();
        poke(12'h030, 16'h0005);
        wr_q.push_back('{12'h030, 16'h0006});
        halt_q.push_back('{16'h5555, 1'b0, 12'h003});
        go();
        wait_done();
        check("isz_mem_inc", {16'h0, mem[12'h030]}, 32'h6);
        // BSA, CLA|CME, CLE+CIL
        do_reset();
        poke(12'h000, 16'h2201);
        poke(12'h001, 16'h7000);
        poke(12'h002, 16'h7000);
        poke(12'h003, 16'h7000);
        poke(12'h004, 16'h5100);
        poke(12'h100, 16'h0000);
        poke(12'h101, 16'h7900);
        poke(12'h102, 16'h7001);
        poke(12'h103, 16'h2200);
        poke(12'h104, 16'h7400);
        poke(12'h105, 16'h7040);
        poke(12'h106, 16'h7001);
        poke(12'h200, 16'h8000);
        poke(12'h201, 16'h1111);
        wr_q.push_back('{12'h100, 16'h0005});
        halt_q.push_back('{16'h0000, 1'b1, 12'h103});
        go();
        wait_done();
        check("bsa_mem", {16'h0, mem[12'h100]}, 32'h5);
        halt_q.push_back('{16'h0000, 1'b1, 12'h107});
        go();
        wait_done();
        // reset during STA T4 with start held
        do_reset();
        poke(12'h000, 16'h2010);
        poke(12'h010, 16'hABCD);
        poke(12'h001, 16'h3011);
        poke(12'h011, 16'h0000);
        go();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CLK);
            found = run && sc == 3'd3 && ir[15:12] == 4'h3;
        end
        check("sta_t3_reached", {31'h0, found}, 32'h1);
        @(posedge CLK);
        #1 rst = 1'b1;
        start = 1'b1;
        #1 check("abort_sc_t4", {29'h0, sc}, 32'h4);
        check("abort_we_gated", {31'h0, mem_we}, 32'h0);
        @(posedge CLK);
        #1 check("abort_mem", {16'h0, mem[12'h011]}, 32'h0);
        check("abort_ac", {16'h0, ac}, 32'h0);
        check("abort_pc", {20'h0, pc}, 32'h0);
        check("abort_ir", {16'h0, ir}, 32'h0);
        check("abort_e", {31'h0, e}, 32'h0);
        check("abort_sc", {29'h0, sc}, 32'h0);
        check("abort_run", {31'h0, run}, 32'h0);
        check("abort_re", {31'h0, mem_re}, 32'h0);
        @(posedge CLK);
        #1 check("abort_run_held", {31'h0, run}, 32'h0);
        rst = 1'b0;
        start = 1'b0;
        @(posedge CLK);
        #1 check("abort_run_after", {31'h0, run}, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end
endmodule
